alu16_sequencer: RTL and testbench

//   Runs 16-bit SM83 arithmetic (ADD HL,rr / INC rr / DEC rr / ADD SP,e8) over the shared 8-bit ALU.

---
 rtl/alu16_sequencer_if.sv | 38 +++
 rtl/alu16_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu16_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu16_sequencer_if.sv
// rtl/alu16_sequencer_if.sv - request/response and 8-bit ALU bus bundle for alu16_sequencer
//
// Purpose: groups every non-clock, non-reset signal of alu16_sequencer.
//   slave  : the sequencer itself (takes requests, drives the ALU inputs)
//   master : the environment (CPU control issuing requests plus the combinational ALU)
// Signals:
//   start, op[1:0], operand_a[15:0], operand_b[15:0], flags_in[3:0]   request side
//   busy, done, result[15:0], flags_out[3:0]                          response side
//   alu_a[7:0], alu_b[7:0], alu_op[4:0], alu_flag_in[3:0]             to the ALU
//   alu_out[7:0], alu_flag_out[3:0]                                   from the ALU
// Flag nibbles are CHNZ: bit0 C, bit1 H, bit2 N, bit3 Z.
interface alu16_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [3:0]  flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags_out;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  alu_op;
    logic [3:0]  alu_flag_in;
    logic [7:0]  alu_out;
    logic [3:0]  alu_flag_out;

    modport slave (
        input  start, op, operand_a, operand_b, flags_in, alu_out, alu_flag_out,
        output busy, done, result, flags_out, alu_a, alu_b, alu_op, alu_flag_in
    );

    modport master (
        output start, op, operand_a, operand_b, flags_in, alu_out, alu_flag_out,
        input  busy, done, result, flags_out, alu_a, alu_b, alu_op, alu_flag_in
    );
endinterface

// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - two-pass 16-bit SM83 arithmetic over a shared 8-bit ALU
//
// Purpose: executes ADD HL,rr / INC rr / DEC rr / ADD SP,e8 as a low-byte ADD pass
//   followed by a high-byte ADC pass chained on the low-pass carry, then assembles
//   the 16-bit result and CHNZ flags.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    alu16_sequencer_if.slave (request, response and ALU signals)
module alu16_sequencer #(
    parameter logic [4:0] ALU_OP_ADD = 5'b00000,
    parameter logic [4:0] ALU_OP_ADC = 5'b00001
) (
    input  logic              clk,
    input  logic              reset,
    alu16_sequencer_if.slave  bus
);

    localparam logic [1:0] OP_ADD16  = 2'd0;
    localparam logic [1:0] OP_INC16  = 2'd1;
    localparam logic [1:0] OP_DEC16  = 2'd2;
    localparam logic [1:0] OP_ADD_SP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [1:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  flags_q;
    logic [7:0]  lo_byte_q;
    logic        lo_c_q;
    logic        lo_h_q;
    logic [15:0] result_q;
    logic [3:0]  flags_out_q;
    logic        done_q;

    logic [7:0]  b_lo;
    logic [7:0]  b_hi;
    logic [3:0]  flags_final;

    // Every operation is reduced to a plain 16-bit add; INC/DEC/ADD_SP only
    // differ in which addend bytes are fed to the two passes.
    always_comb begin
        b_lo = 8'h00;
        b_hi = 8'h00;
        case (op_q)
            OP_ADD16: begin
                b_lo = b_q[7:0];
                b_hi = b_q[15:8];
            end
            OP_INC16: begin
                b_lo = 8'h01;
                b_hi = 8'h00;
            end
            OP_DEC16: begin
                // x + 0xFFFF wraps to x - 1
                b_lo = 8'hFF;
                b_hi = 8'hFF;
            end
            OP_ADD_SP: begin
                b_lo = b_q[7:0];
                b_hi = {8{b_q[7]}};
            end
            default: begin
                b_lo = 8'h00;
                b_hi = 8'h00;
            end
        endcase
    end

    // Final flags, evaluated during the HI pass. ADD SP,e8 reports the
    // low-byte carries; the ALU's own N/Z outputs are never trusted.
    always_comb begin
        flags_final = flags_q;
        case (op_q)
            OP_ADD16:  flags_final = {flags_q[3], 1'b0, bus.alu_flag_out[1], bus.alu_flag_out[0]};
            OP_INC16:  flags_final = flags_q;
            OP_DEC16:  flags_final = flags_q;
            OP_ADD_SP: flags_final = {2'b00, lo_h_q, lo_c_q};
            default:   flags_final = flags_q;
        endcase
    end

    // Next state and ALU drive.
    always_comb begin
        state_d         = state_q;
        bus.alu_a       = 8'h00;
        bus.alu_b       = 8'h00;
        bus.alu_op      = ALU_OP_ADD;
        bus.alu_flag_in = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LO;
                end
            end
            S_LO: begin
                bus.alu_a       = a_q[7:0];
                bus.alu_b       = b_lo;
                bus.alu_op      = ALU_OP_ADD;
                bus.alu_flag_in = 4'b0000;
                state_d         = S_HI;
            end
            S_HI: begin
                bus.alu_a       = a_q[15:8];
                bus.alu_b       = b_hi;
                bus.alu_op      = ALU_OP_ADC;
                bus.alu_flag_in = {3'b000, lo_c_q};
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            flags_q     <= 4'b0000;
            lo_byte_q   <= 8'h00;
            lo_c_q      <= 1'b0;
            lo_h_q      <= 1'b0;
            result_q    <= 16'h0000;
            flags_out_q <= 4'b0000;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_HI);
            if (state_q == S_IDLE && bus.start) begin
                op_q    <= bus.op;
                a_q     <= bus.operand_a;
                b_q     <= bus.operand_b;
                flags_q <= bus.flags_in;
            end
            if (state_q == S_LO) begin
                lo_byte_q <= bus.alu_out;
                lo_c_q    <= bus.alu_flag_out[0];
                lo_h_q    <= bus.alu_flag_out[1];
            end
            if (state_q == S_HI) begin
                result_q    <= {bus.alu_out, lo_byte_q};
                flags_out_q <= flags_final;
            end
        end
    end

    assign bus.busy      = (state_q == S_LO) || (state_q == S_HI);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.flags_out = flags_out_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// tb/tb_alu16_sequencer.sv - self-checking bench for alu16_sequencer
module tb_alu16_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu16_sequencer_if bus ();

    alu16_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational 8-bit ALU: ADD ignores carry-in, ADC adds flag C.
    // N is deliberately driven high so any leak into flags_out is visible.
    logic       alu_cin;
    logic [8:0] alu_sum;
    logic [4:0] alu_nib;
    assign alu_cin  = (bus.alu_op == 5'b00001) ? bus.alu_flag_in[0] : 1'b0;
    assign alu_sum  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, alu_cin};
    assign alu_nib  = {1'b0, bus.alu_a[3:0]} + {1'b0, bus.alu_b[3:0]} + {4'h0, alu_cin};
    assign bus.alu_out      = alu_sum[7:0];
    assign bus.alu_flag_out = {(alu_sum[7:0] == 8'h00), 1'b1, alu_nib[4], alu_sum[8]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole 16-bit arithmetic from the SM83 rules. Returns {flags, result}.
    function automatic logic [19:0] ref_model(input logic [1:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [3:0] f);
        int unsigned ai;
        int unsigned bi;
        int unsigned ei;
        int          es;
        int unsigned r;
        logic        h;
        logic        c;
        logic [3:0]  fl;
        ai = a;
        bi = b;
        ei = b[7:0];
        es = (ei >= 128) ? int'(ei) - 256 : int'(ei);
        case (op)
            2'd0: begin
                r  = (ai + bi) % 65536;
                h  = ((ai % 4096) + (bi % 4096)) > 4095;
                c  = (ai + bi) > 65535;
                fl = {f[3], 1'b0, h, c};
            end
            2'd1: begin
                r  = (ai + 1) % 65536;
                fl = f;
            end
            2'd2: begin
                r  = (ai == 0) ? 65535 : ai - 1;
                fl = f;
            end
            default: begin
                r  = unsigned'((int'(ai) + es + 65536) % 65536);
                h  = ((ai % 16) + (ei % 16)) > 15;
                c  = ((ai % 256) + ei) > 255;
                fl = {2'b00, h, c};
            end
        endcase
        return {fl, r[15:0]};
    endfunction

    function automatic logic [7:0] exp_b_lo(input logic [1:0] op, input logic [15:0] b);
        case (op)
            2'd1:    return 8'h01;
            2'd2:    return 8'hFF;
            default: return b[7:0];
        endcase
    endfunction

    // Called #1 after a rising edge with the sequencer idle. Issues one request,
    // scrambles the request inputs after acceptance, checks both ALU passes,
    // the latency, result/flags, and that done drops while outputs hold.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] f,
                          input logic [15:0] er, input logic [3:0] ef);
        int lat;
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.flags_in  = f;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.op        = 2'($urandom);
        bus.operand_a = 16'($urandom);
        bus.operand_b = 16'($urandom);
        bus.flags_in  = 4'($urandom);
        check({tag, " lo busy"}, 32'(bus.busy), 32'd1);
        check({tag, " lo alu_a"}, 32'(bus.alu_a), 32'(a[7:0]));
        check({tag, " lo alu_b"}, 32'(bus.alu_b), 32'(exp_b_lo(op, b)));
        check({tag, " lo alu_op"}, 32'(bus.alu_op), 32'd0);
        check({tag, " lo alu_flag_in"}, 32'(bus.alu_flag_in), 32'd0);
        lat = 1;
        while (!bus.done && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2) begin
                check({tag, " hi busy"}, 32'(bus.busy), 32'd1);
                check({tag, " hi alu_a"}, 32'(bus.alu_a), 32'(a[15:8]));
                check({tag, " hi alu_op"}, 32'(bus.alu_op), 32'd1);
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " result"}, 32'(bus.result), 32'(er));
        check({tag, " flags"}, 32'(bus.flags_out), 32'(ef));
        check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 32'(bus.done), 32'd0);
        check({tag, " result held"}, 32'(bus.result), 32'(er));
        check({tag, " flags held"}, 32'(bus.flags_out), 32'(ef));
    endtask

    initial begin
        logic [19:0] m;
        logic [1:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [3:0]  rf;
        int          dones;

        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'd0;
        bus.operand_a = 16'h0000;
        bus.operand_b = 16'h0000;
        bus.flags_in  = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check("reset flags", 32'(bus.flags_out), 32'd0);
        check("reset alu_a", 32'(bus.alu_a), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("add16 half", 2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
        run_op("add16 wrap", 2'd0, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);
        run_op("inc16",      2'd1, 16'h00FF, 16'h1234, 4'b0101, 16'h0100, 4'b0101);
        run_op("dec16",      2'd2, 16'h0000, 16'h1234, 4'b0101, 16'hFFFF, 4'b0101);
        run_op("addsp neg",  2'd3, 16'h0005, 16'h00FF, 4'b1111, 16'h0004, 4'b0011);
        run_op("addsp pos",  2'd3, 16'hFFF8, 16'hAA08, 4'b1100, 16'h0000, 4'b0011);

        // start held into the busy cycle is ignored; start in the done cycle is taken
        bus.start     = 1'b1;
        bus.op        = 2'd0;
        bus.operand_a = 16'h1234;
        bus.operand_b = 16'h1111;
        bus.flags_in  = 4'b0000;
        dones         = 0;
        @(posedge clk);
        #1;
        bus.operand_a = 16'h0F00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones += int'(bus.done);
        @(posedge clk);
        #1;
        check("b2b first done", 32'(bus.done), 32'd1);
        check("b2b first result", 32'(bus.result), 32'h2345);
        bus.start     = 1'b1;
        bus.op        = 2'd1;
        bus.operand_a = 16'hABCD;
        bus.flags_in  = 4'b0110;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b second busy", 32'(bus.busy), 32'd1);
        check("b2b no extra done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        check("b2b no extra done hi", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        check("b2b second done", 32'(bus.done), 32'd1);
        check("b2b second result", 32'(bus.result), 32'hABCE);
        check("b2b second flags", 32'(bus.flags_out), 32'b0110);
        @(posedge clk);
        #1;
        dones += int'(bus.done);
        check("b2b stray done", 32'(dones), 32'd0);

        // reset asserted during the HI pass aborts without a done pulse
        bus.start     = 1'b1;
        bus.op        = 2'd0;
        bus.operand_a = 16'h2222;
        bus.operand_b = 16'h3333;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("abort in hi", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort done", 32'(bus.done), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort result", 32'(bus.result), 32'd0);
        check("abort flags", 32'(bus.flags_out), 32'd0);
        check("abort alu_a", 32'(bus.alu_a), 32'd0);
        check("abort alu_b", 32'(bus.alu_b), 32'd0);
        check("abort alu_op", 32'(bus.alu_op), 32'd0);
        check("abort alu_flag_in", 32'(bus.alu_flag_in), 32'd0);
        @(posedge clk);
        #1;
        check("abort late done", 32'(bus.done), 32'd0);

        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rf  = 4'($urandom);
            m   = ref_model(rop, ra, rb, rf);
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rf, m[15:0], m[19:16]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
